vga_ball_renderer: RTL and testbench

- Consumer side of the ball-position interface: samples `pos_x`/`pos_y` from the ball controller once per frame and draws a SIZE×SIZE square on a 640×480 VGA raster.
- Generates the VGA horizontal/vertical timing (sync, data-enable, pixel coordinates).
- Emits `frame_tick`, a once-per-frame enable that the ball controller uses as its update strobe, so the ball moves one step per frame.
- Sits between the ball controller and the board's VGA DAC pins.

---
 rtl/vga_pkg.sv | 14 +
 rtl/vga_timing.sv | 48 ++++
 rtl/vga_ball_renderer.sv | 74 +++++++
 tb/tb_vga_ball_renderer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 VGA timing defaults and colour width shared by VGA demos.
package vga_pkg;
    localparam int VGA_H_DISP  = 640;
    localparam int VGA_H_FP    = 16;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_V_DISP  = 480;
    localparam int VGA_V_FP    = 10;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BP    = 33;
    localparam int VGA_H_TOTAL = VGA_H_DISP + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_DISP + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int RGB_W       = 12;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: raster counters and unregistered sync/enable/tick strobes.
module vga_timing import vga_pkg::*; #(
    parameter int H_DISP   = VGA_H_DISP,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_DISP   = VGA_V_DISP,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int POS_BITS = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [POS_BITS-1:0] h_cnt,
    output logic [POS_BITS-1:0] v_cnt,
    output logic                hs_raw,
    output logic                vs_raw,
    output logic                de_raw,
    output logic                frame_tick_raw,
    output logic                frame_end_raw
);
    localparam logic [POS_BITS-1:0] H_END = POS_BITS'(H_DISP + H_FP + H_SYNC + H_BP - 1);
    localparam logic [POS_BITS-1:0] V_END = POS_BITS'(V_DISP + V_FP + V_SYNC + V_BP - 1);
    localparam logic [POS_BITS-1:0] H_VIS = POS_BITS'(H_DISP);
    localparam logic [POS_BITS-1:0] V_VIS = POS_BITS'(V_DISP);
    localparam logic [POS_BITS-1:0] H_SS  = POS_BITS'(H_DISP + H_FP);
    localparam logic [POS_BITS-1:0] H_SE  = POS_BITS'(H_DISP + H_FP + H_SYNC);
    localparam logic [POS_BITS-1:0] V_SS  = POS_BITS'(V_DISP + V_FP);
    localparam logic [POS_BITS-1:0] V_SE  = POS_BITS'(V_DISP + V_FP + V_SYNC);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= (h_cnt == H_END) ? '0 : h_cnt + 1'b1;
            if (h_cnt == H_END)
                v_cnt <= (v_cnt == V_END) ? '0 : v_cnt + 1'b1;
        end

    assign de_raw         = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_raw         = !((h_cnt >= H_SS) && (h_cnt < H_SE));
    assign vs_raw         = !((v_cnt >= V_SS) && (v_cnt < V_SE));
    // first blanking line gives the ball controller a whole blanking period to update
    assign frame_tick_raw = (h_cnt == '0) && (v_cnt == V_VIS);
    assign frame_end_raw  = (h_cnt == H_END) && (v_cnt == V_END);
endmodule

// File: rtl/vga_ball_renderer.sv
// vga_ball_renderer: draws a SIZE x SIZE ball at a per-frame latched position on a VGA raster.
module vga_ball_renderer import vga_pkg::*; #(
    parameter int               H_DISP   = VGA_H_DISP,
    parameter int               H_FP     = VGA_H_FP,
    parameter int               H_SYNC   = VGA_H_SYNC,
    parameter int               H_BP     = VGA_H_BP,
    parameter int               V_DISP   = VGA_V_DISP,
    parameter int               V_FP     = VGA_V_FP,
    parameter int               V_SYNC   = VGA_V_SYNC,
    parameter int               V_BP     = VGA_V_BP,
    parameter int               POS_BITS = 10,
    parameter int               SIZE     = 5,
    parameter logic [RGB_W-1:0] BALL_RGB = 12'hFFF,
    parameter logic [RGB_W-1:0] BG_RGB   = 12'h000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [POS_BITS-1:0] pos_x,
    input  logic [POS_BITS-1:0] pos_y,
    output logic                frame_tick,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic [POS_BITS-1:0] pix_x,
    output logic [POS_BITS-1:0] pix_y,
    output logic [RGB_W-1:0]    rgb
);
    logic [POS_BITS-1:0] h_cnt, v_cnt, lat_x, lat_y;
    logic                hs_raw, vs_raw, de_raw, frame_tick_raw, frame_end_raw, hit;
    logic [POS_BITS:0]   hx, vy, lx, ly;

    vga_timing #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .POS_BITS(POS_BITS)
    ) u_timing (
        .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .hs_raw(hs_raw), .vs_raw(vs_raw), .de_raw(de_raw),
        .frame_tick_raw(frame_tick_raw), .frame_end_raw(frame_end_raw)
    );

    // one spare bit so a ball at the right/bottom edge clips instead of wrapping to 0
    assign hx  = {1'b0, h_cnt};
    assign vy  = {1'b0, v_cnt};
    assign lx  = {1'b0, lat_x};
    assign ly  = {1'b0, lat_y};
    assign hit = (hx >= lx) && (hx < lx + (POS_BITS+1)'(SIZE)) &&
                 (vy >= ly) && (vy < ly + (POS_BITS+1)'(SIZE));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            lat_x      <= '0;
            lat_y      <= '0;
            frame_tick <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            de         <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            rgb        <= '0;
        end else begin
            if (frame_end_raw) begin
                lat_x <= pos_x;
                lat_y <= pos_y;
            end
            frame_tick <= frame_tick_raw;
            hsync      <= hs_raw;
            vsync      <= vs_raw;
            de         <= de_raw;
            pix_x      <= h_cnt;
            pix_y      <= v_cnt;
            rgb        <= de_raw ? (hit ? BALL_RGB : BG_RGB) : '0;
        end
endmodule

// File: tb/tb_vga_ball_renderer.sv
// tb_vga_ball_renderer: directed checks of raster timing, ball drawing and frame isolation on a shrunk raster.
module tb_vga_ball_renderer;
    localparam int HD = 16, HF = 2, HS = 3, HB = 3;
    localparam int VD = 12, VF = 1, VS = 2, VB = 2;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [11:0] BALL = 12'hFFF;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [9:0]  pos_x = '0, pos_y = '0;
    logic        frame_tick, hsync, vsync, de;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] rgb;
    int total = 0, bad = 0;

    vga_ball_renderer #(
        .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .POS_BITS(10), .SIZE(5), .BALL_RGB(BALL), .BG_RGB(12'h000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pos_x(pos_x), .pos_y(pos_y),
        .frame_tick(frame_tick), .hsync(hsync), .vsync(vsync), .de(de),
        .pix_x(pix_x), .pix_y(pix_y), .rgb(rgb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input string tag, input int bx, input int by, input int exp_ball,
                        input int chg_line, input int nx, input int ny);
        int n, ball, hsn, vsn, den, ft, stray, pixerr;
        logic [11:0] exp;
        n = 0; ball = 0; hsn = 0; vsn = 0; den = 0; ft = 0; stray = 0; pixerr = 0;
        while (!(pix_x == 0 && pix_y == 0) && n < 2 * FRAME) begin
            tick;
            n++;
        end
        chk({tag, "_sync"}, 64'(n < 2 * FRAME), 64'd1);
        for (int i = 0; i < FRAME; i++) begin
            exp = (pix_x < HD && pix_y < VD && pix_x >= bx && pix_x < bx + 5 &&
                   pix_y >= by && pix_y < by + 5) ? BALL : 12'h000;
            if (rgb !== exp) pixerr++;
            if (rgb === BALL) ball++;
            if (de !== (pix_x < HD && pix_y < VD)) stray++;
            if (!de && rgb !== 12'h000) stray++;
            if (de) den++;
            if (!hsync) begin
                hsn++;
                if (pix_x < HD + HF || pix_x >= HD + HF + HS) stray++;
            end
            if (!vsync) begin
                vsn++;
                if (pix_y < VD + VF || pix_y >= VD + VF + VS) stray++;
            end
            if (frame_tick) begin
                ft++;
                if (pix_x != 0 || pix_y != VD) stray++;
            end
            if (chg_line >= 0 && pix_y == chg_line && pix_x == 0) begin
                pos_x = 10'(nx);
                pos_y = 10'(ny);
            end
            tick;
        end
        chk({tag, "_pixels"}, 64'(pixerr), 64'd0);
        chk({tag, "_ball_count"}, 64'(ball), 64'(exp_ball));
        chk({tag, "_hsync_low"}, 64'(hsn), 64'(HS * VT));
        chk({tag, "_vsync_low"}, 64'(vsn), 64'(VS * HT));
        chk({tag, "_de_count"}, 64'(den), 64'(HD * VD));
        chk({tag, "_ticks"}, 64'(ft), 64'd1);
        chk({tag, "_placement"}, 64'(stray), 64'd0);
    endtask

    initial begin
        int n;
        pos_x = 10'd5;
        pos_y = 10'd5;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("reset_outputs", {hsync, vsync, de, frame_tick, rgb, pix_x, pix_y},
                {1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 10'd0, 10'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("first_pixel", {de, pix_x, pix_y, rgb}, {1'b1, 10'd0, 10'd0, BALL});
        tick;
        chk("second_pixel", {de, pix_x, pix_y}, {1'b1, 10'd1, 10'd0});
        n = 2;
        while (!frame_tick && n < 2 * FRAME) begin
            tick;
            n++;
        end
        chk("first_tick_latency", 64'(n), 64'(VD * HT + 1));
        tick;
        chk("tick_one_cycle", 64'(frame_tick), 64'd0);

        scan("ball_5_5", 5, 5, 25, -1, 0, 0);
        scan("isolate_old", 5, 5, 25, 6, 10, 6);
        scan("isolate_new", 10, 6, 25, -1, 0, 0);
        pos_x = 10'd14;
        pos_y = 10'd10;
        scan("pending_pos", 10, 6, 25, -1, 0, 0);
        scan("edge_clip", 14, 10, 4, -1, 0, 0);

        n = 0;
        while (pix_y != 7 && n < 2 * FRAME) begin
            tick;
            n++;
        end
        chk("reach_mid_frame", 64'(n < 2 * FRAME), 64'd1);
        rst_n = 1'b0;
        #2;
        chk("async_reset", {hsync, vsync, de, frame_tick, rgb, pix_x, pix_y},
            {1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 10'd0, 10'd0});
        tick;
        chk("reset_hold", {hsync, vsync, de, rgb, pix_x, pix_y},
            {1'b1, 1'b1, 1'b0, 12'h000, 10'd0, 10'd0});
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("restart_pixel", {de, pix_x, pix_y, rgb}, {1'b1, 10'd0, 10'd0, BALL});
        tick;
        chk("restart_next", {pix_x, pix_y, rgb}, {10'd1, 10'd0, BALL});
        scan("after_reset", 14, 10, 4, -1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
